// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin burst scheduler sharing one UART TX FIFO write port
// between NumReq byte sources. A grant is held for a burst until i_last or
// MaxBurst bytes. Writes are gated on FIFO full and on a synchronized CTS.
//
// Build option: define UART_TX_SCHED_PRIO_EN to make requester 0 win every
// IDLE arbitration it takes part in. Its grants leave the round-robin pointer
// untouched, and there is no preemption inside a burst. Without the macro the
// block is a pure round-robin scheduler.
module uart_tx_sched #(
    parameter int unsigned NumReq   = 4,
    parameter int unsigned MaxBurst = 16
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [NumReq-1:0]         i_req,
    input  logic [NumReq*8-1:0]       i_data,
    input  logic [NumReq-1:0]         i_last,
    output logic [NumReq-1:0]         o_ack,
    output logic                      o_fifo_wr_en,
    output logic [7:0]                o_fifo_wr_data,
    input  logic                      i_fifo_full,
    input  logic                      i_cts,
    output logic [$clog2(NumReq)-1:0] o_grant_id,
    output logic                      o_busy
);

    localparam int unsigned IdW  = $clog2(NumReq);
    localparam int unsigned CntW = $clog2(MaxBurst + 1);

    localparam logic [IdW-1:0]  LastId   = IdW'(NumReq - 1);
    localparam logic [CntW-1:0] CntFinal = CntW'(MaxBurst - 1);

    localparam logic [0:0] StIdle = 1'b0;
    localparam logic [0:0] StXfer = 1'b1;

    logic [0:0]      state_q,     state_d;
    logic [IdW-1:0]  grant_q,     grant_d;
    logic [IdW-1:0]  rr_ptr_q,    rr_ptr_d;
    logic [CntW-1:0] burst_cnt_q, burst_cnt_d;
    logic            cts_meta_q,  cts_meta_d;
    logic            cts_s_q,     cts_s_d;

    logic            req_g;
    logic            last_g;
    logic [7:0]      data_g;
    logic            accept;

    logic            rr_found;
    logic [IdW-1:0]  rr_win;
    logic [IdW-1:0]  arb_win;
    logic [IdW-1:0]  rel_ptr;
    int unsigned     arb_sum;

    // Select the granted requester's valid, last flag and byte.
    always_comb begin
        req_g  = 1'b0;
        last_g = 1'b0;
        data_g = 8'h00;
        for (int unsigned k = 0; k < NumReq; k++) begin
            if (grant_q == IdW'(k)) begin
                req_g  = i_req[k];
                last_g = i_last[k];
                data_g = i_data[k*8 +: 8];
            end
        end
    end

    // A byte moves only while bursting, with the FIFO ready and the peer clear;
    // reset dominates so nothing is written during the reset cycle.
    assign accept = (state_q == StXfer) & req_g & ~i_fifo_full & cts_s_q & ~i_rst;

    // Zero-latency write port and one-hot accept strobe.
    always_comb begin
        o_ack = '0;
        for (int unsigned k = 0; k < NumReq; k++) begin
            o_ack[k] = accept && (grant_q == IdW'(k));
        end
        o_fifo_wr_en   = accept;
        o_fifo_wr_data = accept ? data_g : 8'h00;
    end

    assign o_busy     = (state_q == StXfer);
    assign o_grant_id = grant_q;

    // Round-robin search: first requester after rr_ptr, wrapping modulo NumReq.
    always_comb begin
        rr_found = 1'b0;
        rr_win   = '0;
        arb_sum  = 0;
        for (int unsigned off = 1; off <= NumReq; off++) begin
            arb_sum = 32'(rr_ptr_q) + off;
            if (arb_sum >= NumReq) begin
                arb_sum = arb_sum - NumReq;
            end
            for (int unsigned k = 0; k < NumReq; k++) begin
                if (!rr_found && (arb_sum == k) && i_req[k]) begin
                    rr_found = 1'b1;
                    rr_win   = IdW'(k);
                end
            end
        end
    end

`ifdef UART_TX_SCHED_PRIO_EN
    // Requester 0 overrides the rotation and never advances the pointer.
    always_comb begin
        arb_win = i_req[0] ? '0 : rr_win;
        rel_ptr = (grant_q == '0) ? rr_ptr_q : grant_q;
    end
`else
    // Pure rotation: the releasing owner becomes the new pointer.
    always_comb begin
        arb_win = rr_win;
        rel_ptr = grant_q;
    end
`endif

    // Next-state logic: arbitration in IDLE, burst accounting and release in XFER.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        cts_meta_d  = i_cts;
        cts_s_d     = cts_meta_q;

        case (state_q)
            StIdle: begin
                if (|i_req) begin
                    grant_d     = arb_win;
                    burst_cnt_d = '0;
                    state_d     = StXfer;
                end
            end
            StXfer: begin
                if (!req_g) begin
                    // Owner abandoned the burst: release with no byte.
                    state_d     = StIdle;
                    rr_ptr_d    = rel_ptr;
                    burst_cnt_d = '0;
                end else if (accept) begin
                    if (last_g || (burst_cnt_q == CntFinal)) begin
                        state_d     = StIdle;
                        rr_ptr_d    = rel_ptr;
                        burst_cnt_d = '0;
                    end else begin
                        burst_cnt_d = burst_cnt_q + CntW'(1);
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State register with synchronous active-high reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= StIdle;
            grant_q     <= '0;
            rr_ptr_q    <= LastId;
            burst_cnt_q <= '0;
            cts_meta_q  <= 1'b0;
            cts_s_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
            cts_meta_q  <= cts_meta_d;
            cts_s_q     <= cts_s_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: directed and random checks of uart_tx_sched against a
// cycle-level behavioural model built from per-requester byte queues.
module tb_uart_tx_sched;

    localparam int N     = 4;
    localparam int MB    = 16;
    localparam int DEPTH = 1024;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*8-1:0] data;
    logic [N-1:0]   last;
    logic [N-1:0]   o_ack;
    logic           o_fifo_wr_en;
    logic [7:0]     o_fifo_wr_data;
    logic           full;
    logic           cts;
    logic [1:0]     o_grant_id;
    logic           o_busy;

    always #5 clk = ~clk;

    uart_tx_sched #(.NumReq(N), .MaxBurst(MB)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_req          (req),
        .i_data         (data),
        .i_last         (last),
        .o_ack          (o_ack),
        .o_fifo_wr_en   (o_fifo_wr_en),
        .o_fifo_wr_data (o_fifo_wr_data),
        .i_fifo_full    (full),
        .i_cts          (cts),
        .o_grant_id     (o_grant_id),
        .o_busy         (o_busy)
    );

    // Byte sources
    logic [7:0] mem [N][DEPTH];
    bit         lst [N][DEPTH];
    int         head [N];
    int         tail [N];
    bit         en   [N];

    // Reference model
    bit m_busy;
    int m_owner;
    int m_cnt;
    int m_ptr;
    bit m_c1;
    bit m_c2;

    int n_cmp;
    int n_bad;
    int wr_count;
    int gseq[$];
    bit dut_busy_prev;
    int exp_seq[$];
    int w0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int k, input int n, input bit with_last);
        for (int i = 0; i < n; i++) begin
            if (tail[k] < DEPTH) begin
                mem[k][tail[k]] = 8'($urandom);
                lst[k][tail[k]] = with_last && (i == n - 1);
                tail[k]++;
            end
        end
    endtask

    function automatic bit pending();
        bit p = 1'b0;
        for (int k = 0; k < N; k++) if (head[k] < tail[k]) p = 1'b1;
        return p;
    endfunction

    task automatic drive();
        for (int k = 0; k < N; k++) begin
            if (head[k] < tail[k]) begin
                req[k]          = en[k];
                data[k*8 +: 8]  = mem[k][head[k]];
                last[k]         = lst[k][head[k]];
            end else begin
                req[k]          = 1'b0;
                data[k*8 +: 8]  = 8'h00;
                last[k]         = 1'b0;
            end
        end
    endtask

    function automatic int pick(input logic [N-1:0] r);
`ifdef UART_TX_SCHED_PRIO_EN
        if (r[0]) return 0;
`endif
        for (int off = 1; off <= N; off++) begin
            int idx;
            idx = (m_ptr + off) % N;
            if (r[idx]) return idx;
        end
        return 0;
    endfunction

    function automatic void release_grant();
        m_busy = 1'b0;
`ifdef UART_TX_SCHED_PRIO_EN
        if (m_owner != 0) m_ptr = m_owner;
`else
        m_ptr = m_owner;
`endif
    endfunction

    function automatic void model_reset();
        m_busy  = 1'b0;
        m_owner = 0;
        m_ptr   = N - 1;
        m_cnt   = 0;
        m_c1    = 1'b0;
        m_c2    = 1'b0;
    endfunction

    // One clock: drive at the falling edge, check, then advance the model at the rising edge.
    task automatic cycle();
        bit           acc;
        logic [N-1:0] eack;
        logic [7:0]   ed;
        logic [N-1:0] r;
        logic [N-1:0] l;
        bit           c;
        bit           rs;
        drive();
        #1;
        r  = req;
        l  = last;
        c  = cts;
        rs = rst;
        acc = !rs && m_busy && r[m_owner] && !full && m_c2;
        for (int k = 0; k < N; k++) eack[k] = acc && (m_owner == k);
        ed = acc ? mem[m_owner][head[m_owner]] : 8'h00;
        chk("ack", 32'(o_ack), 32'(eack));
        chk("wr_en", 32'(o_fifo_wr_en), 32'(acc));
        chk("wr_data", 32'(o_fifo_wr_data), 32'(ed));
        chk("busy", 32'(o_busy), 32'(m_busy));
        if (m_busy) chk("grant_id", 32'(o_grant_id), 32'(m_owner));
        if (o_busy === 1'b1 && !dut_busy_prev) gseq.push_back(int'(o_grant_id));
        dut_busy_prev = (o_busy === 1'b1);
        if (o_fifo_wr_en === 1'b1) wr_count++;
        @(posedge clk);
        if (rs) begin
            model_reset();
        end else begin
            m_c2 = m_c1;
            m_c1 = c;
            if (!m_busy) begin
                if (r != '0) begin
                    m_owner = pick(r);
                    m_busy  = 1'b1;
                    m_cnt   = 0;
                end
            end else if (!r[m_owner]) begin
                release_grant();
            end else if (acc) begin
                head[m_owner]++;
                m_cnt++;
                if (l[m_owner] || m_cnt == MB) release_grant();
            end
        end
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic drain(input int max);
        int n = 0;
        while ((pending() || m_busy) && n < max) begin
            cycle();
            n++;
        end
        chk("drain_done", 32'(pending() || m_busy), 32'(0));
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        wr_count = 0;
        dut_busy_prev = 1'b0;
        rst  = 1'b1;
        full = 1'b0;
        cts  = 1'b0;
        req  = '0;
        data = '0;
        last = '0;
        for (int k = 0; k < N; k++) begin
            head[k] = 0;
            tail[k] = 0;
            en[k]   = 1'b1;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        model_reset();

        // Reset state
        cycle();
        chk("rst_busy", 32'(o_busy), 32'(0));
        chk("rst_grant", 32'(o_grant_id), 32'(0));
        chk("rst_wr_en", 32'(o_fifo_wr_en), 32'(0));
        rst = 1'b0;
        cts = 1'b1;
        run(3);

        // 1: all four request two-byte bursts; requester 0 has two
        gseq.delete();
        wr_count = 0;
        push(0, 2, 1); push(0, 2, 1);
        push(1, 2, 1); push(2, 2, 1); push(3, 2, 1);
        drain(200);
`ifdef UART_TX_SCHED_PRIO_EN
        exp_seq = '{0, 0, 1, 2, 3};
`else
        exp_seq = '{0, 1, 2, 3, 0};
`endif
        chk("t1_ngrants", 32'(gseq.size()), 32'(5));
        for (int i = 0; i < 5; i++)
            chk("t1_order", 32'((i < gseq.size()) ? gseq[i] : -1), 32'(exp_seq[i]));
        chk("t1_writes", 32'(wr_count), 32'(10));

        // 2: 40-byte stream with no last, forced release every MB bytes
        gseq.delete();
        wr_count = 0;
        push(2, 40, 0);
        drain(300);
        chk("t2_writes", 32'(wr_count), 32'(40));
        chk("t2_ngrants", 32'(gseq.size()), 32'(3));
        for (int i = 0; i < gseq.size(); i++) chk("t2_owner", 32'(gseq[i]), 32'(2));

        // 3: FIFO full for 5 cycles mid-burst
        wr_count = 0;
        push(1, 6, 1);
        run(3);
        full = 1'b1;
        w0 = wr_count;
        run(5);
        chk("t3_nowrite", 32'(wr_count - w0), 32'(0));
        chk("t3_grant", 32'(o_grant_id), 32'(1));
        full = 1'b0;
        drain(100);
        chk("t3_writes", 32'(wr_count), 32'(6));

        // 4: CTS drop mid-burst
        wr_count = 0;
        push(0, 8, 1);
        run(3);
        cts = 1'b0;
        run(6);
        cts = 1'b1;
        drain(100);
        chk("t4_writes", 32'(wr_count), 32'(8));

        // 5: requester 3 abandons after one byte; pending requester 0 follows
        wr_count = 0;
        push(3, 3, 0);
        run(2);
        en[3] = 1'b0;
        push(0, 2, 1);
        gseq.delete();
        run(8);
        chk("t5_next_owner", 32'((gseq.size() > 0) ? gseq[0] : -1), 32'(0));
        chk("t5_writes", 32'(wr_count), 32'(3));
        en[3] = 1'b1;
        drain(100);

        // 6: reset mid-burst with requests held
        push(0, 10, 0);
        push(1, 10, 0);
        run(4);
        rst = 1'b1;
        w0 = wr_count;
        cycle();
        chk("t6_no_rst_write", 32'(wr_count - w0), 32'(0));
        chk("t6_busy_after_rst", 32'(o_busy), 32'(0));
        rst = 1'b0;
        gseq.delete();
        drain(200);
        chk("t6_first_owner", 32'((gseq.size() > 0) ? gseq[0] : -1), 32'(0));

        // 7: 0 and 1 compete for three bursts each
        gseq.delete();
        for (int i = 0; i < 3; i++) begin
            push(0, 2, 1);
            push(1, 2, 1);
        end
        drain(200);
`ifdef UART_TX_SCHED_PRIO_EN
        exp_seq = '{0, 0, 0, 1, 1, 1};
`else
        exp_seq = '{0, 1, 0, 1, 0, 1};
`endif
        for (int i = 0; i < 6; i++)
            chk("t7_order", 32'((i < gseq.size()) ? gseq[i] : -1), 32'(exp_seq[i]));

        // Random traffic
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 7) == 0)
                push(int'($urandom_range(0, N - 1)), int'($urandom_range(1, 6)), 1'($urandom_range(0, 1)));
            for (int k = 0; k < N; k++) en[k] = ($urandom_range(0, 9) != 0);
            full = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 39) == 0) cts = ~cts;
            rst = ($urandom_range(0, 299) == 0);
            cycle();
        end
        rst  = 1'b0;
        full = 1'b0;
        cts  = 1'b1;
        for (int k = 0; k < N; k++) en[k] = 1'b1;
        drain(4000);
        run(2);
        chk("end_idle", 32'(o_busy), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
